hold_mon: RTL and testbench
===========================

# hold_mon

Downstream monitor for the hold-output FSM stage. It consumes that stage's burst-level output `g` and its end-of-burst toggle `f`. For each burst it measures the `g`-high length and checks that `f` toggled exactly at or just after the burst end. It reports each burst with a one-cycle valid strobe, plus error flags and a running burst count, for bench scoreboarding and on-chip health checking.

## Interface
- `LEN_W`, 4: width of the length counter and of `len_out`.
- `EXP_LEN`, 6: expected `g`-high length, in cycles.
- `TOG_WIN`, 2: number of cycles after `g` falls in which an `f` toggle is still accepted. Must be ≥1.

- `clk` input 1: clock.
- `rst` input 1: reset, synchronous, active-high.
- `g_in` input 1: burst level from the upstream FSM.
- `f_in` input 1: toggle output from the upstream FSM.
- `enable` input 1: when high, allows a new burst to be captured.
- `busy` output 1: high when the state is not IDLE.
- `len_vld` output 1: one-cycle strobe marking a burst report.
- `len_out` output LEN_W: measured `g`-high length.
- `len_err` output 1: `len_out` ≠ `EXP_LEN`.
- `tog_err` output 1: `f` toggle missing or early.
- `burst_cnt` output 8: number of bursts reported, wraps at 255→0.

## Operation
- Registered `g_q` tracks `g_in`. A rise is the cycle where `g_in=1` and `g_q=0`.
- `g_q` resets to 1, so a burst already in progress at reset release is ignored.
- **IDLE**:
  - On a rise with `enable=1`: go to MEAS, set `len=1`, set `f_ref=f_in`, clear `early`.
  - A rise with `enable=0` is ignored.
- **MEAS**, on each cycle:
  - If `g_in=1`: `len` increments, saturating at 2^LEN_W−1. If `f_in≠f_ref`, set the sticky `early` flag.
  - If `g_in=0`: if `f_in≠f_ref`, go to REPORT; otherwise go to WAIT_F with `win=0`.
  - Dropping `enable` mid-burst does not abort the burst.
- **WAIT_F**:
  - If `f_in≠f_ref`: go to REPORT.
  - Else if `win==TOG_WIN−1`: go to REPORT with `timeout=1`.
  - Else `win++`.
  - A `g_in` rise in WAIT_F is not captured.
- **REPORT**, lasts exactly one cycle:
  - `len_vld=1`.
  - `len_out=len`.
  - `len_err=(len≠EXP_LEN)`.
  - `tog_err=early|timeout`.
  - Next state: MEAS if a rise with `enable=1` occurs in this cycle, reinitialising `len`, `f_ref` and `early`; otherwise IDLE.
- `len_out`, `len_err` and `tog_err` hold their values until the next REPORT.
- `burst_cnt` increments on entry to REPORT, so the new value is visible in the same cycle as `len_vld`.
- A saturated length reports `len_err=1`, unless `EXP_LEN` equals 2^LEN_W−1.

## Timing
- Reset values:
  - Outputs: `busy`, `len_vld`, `len_out`, `len_err`, `tog_err` and `burst_cnt` all 0.
  - Internal: state=IDLE, `g_q=1`, `len=0`, `win=0`, `f_ref=0`, `early=0`, `timeout=0`.
- Reset asserted in any state returns to IDLE on the next edge. No report is produced for an aborted burst.
- All outputs are registered.
- For `g_in` high in N consecutive sampled cycles: `len_out=N`.
- `len_vld` latency after the first low sample of `g_in`:
  - f toggled by that sample: `len_vld` one cycle later.
  - Toggle k cycles later (k<TOG_WIN): `len_vld` k+1 cycles later.
  - Timeout: `len_vld` TOG_WIN+1 cycles later.
- The upstream FSM toggles `f` on the same edge that drops `g`. This hits the immediate-REPORT path with `tog_err=0`.
- Minimum burst-to-burst spacing without a missed capture: `g` low for ≥1 cycle, and the rise lands in IDLE or REPORT.

## Configuration
- The `HOLD_MON_STAT_EN` macro controls a statistics feature.
- **Defined**:
  - Adds outputs `len_min` and `len_max` (LEN_W each) and `err_cnt` (8 bits, saturating at 255).
  - All three are updated on REPORT entry.
  - `len_min` resets to all-ones; `len_max` and `err_cnt` reset to 0.
  - `err_cnt` increments when `len_err|tog_err` is set for that report.
- **Undefined**: these ports and registers are absent. All other behaviour is identical.

## Test plan
- **Nominal burst:** `g_in` high 6 cycles; `f_in` toggles on the same edge `g_in` falls. Expect `len_vld` one cycle after the first low sample, `len_out=6`, `len_err=0`, `tog_err=0`, `burst_cnt=1`.
- **Late toggle / timeout:** `g_in` high 6 cycles.
  - Toggle 1 cycle after the fall: `tog_err=0`, `len_vld` 2 cycles after the fall.
  - No toggle: `tog_err=1`, `len_vld` 3 cycles after the fall.
- **Early toggle and wrong length:** `f_in` toggles mid-burst; `g_in` high 9 cycles. Expect `len_out=9`, `len_err=1`, `tog_err=1`.
- **Saturation and wrap:** `g_in` high 20 cycles with `LEN_W=4`. Expect `len_out=15`, `len_err=1`. Then send 256 nominal bursts and expect `burst_cnt` to wrap to 0.
- **Enable, back-to-back, reset:**
  - `enable=0` at a rise: no report.
  - A rise during the REPORT cycle: the burst is captured and `len_out` is correct.
  - `rst` asserted mid-MEAS: `busy=0` next cycle, no `len_vld`, `burst_cnt` cleared.
  - `g_in=1` at reset release: ignored.
- **HOLD_MON_STAT_EN:** bursts of length 6, 4 and 9 with one toggle error. Expect `len_min=4`, `len_max=9`, `err_cnt=2`.

Source files
------------

// File: rtl/hold_mon.sv
// Purpose: per-burst monitor of the hold-output stage: measures g-high length, checks the f toggle, counts bursts.
// Latency: len_vld rises 1 cycle after g's first low sample (toggle seen), k+1 if the toggle is k cycles late, TOG_WIN+1 on timeout.
// Backpressure: none; passive observer, never stalls upstream. Optional statistics under HOLD_MON_STAT_EN.
module hold_mon #(
  parameter int LEN_W   = 4,
  parameter int EXP_LEN = 6,
  parameter int TOG_WIN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_in,
  input  logic             f_in,
  input  logic             enable,
  output logic             busy,
  output logic             len_vld,
  output logic [LEN_W-1:0] len_out,
  output logic             len_err,
  output logic             tog_err,
  output logic [7:0]       burst_cnt
`ifdef HOLD_MON_STAT_EN
  ,
  output logic [LEN_W-1:0] len_min,
  output logic [LEN_W-1:0] len_max,
  output logic [7:0]       err_cnt
`endif
);

  // win only has to count 0..TOG_WIN-1
  localparam int WIN_W = (TOG_WIN > 1) ? $clog2(TOG_WIN) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TOG_WIN - 1);
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;
  localparam logic [LEN_W-1:0] LEN_EXP  = LEN_W'(EXP_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    WAIT_F = 2'd2,
    REPORT = 2'd3
  } state_t;

  state_t           state;
  logic             g_q;
  logic [LEN_W-1:0] len;
  logic [WIN_W-1:0] win;
  logic             f_ref;
  logic             early;

  logic             toggled;
  logic             cap;
  logic             rpt_go;
  logic             rpt_to;
  logic             rpt_tog;
  logic             rpt_len_err;

  // Decode edge/toggle events and the "entering REPORT this edge" condition shared by FSM and report registers
  always_comb begin
    toggled     = (f_in != f_ref);
    cap         = g_in & ~g_q & enable;
    rpt_to      = 1'b0;
    rpt_go      = 1'b0;
    if (state == MEAS) begin
      rpt_go = ~g_in & toggled;
    end else if (state == WAIT_F) begin
      rpt_to = ~toggled & (win == WIN_LAST);
      rpt_go = toggled | rpt_to;
    end
    rpt_tog     = early | rpt_to;
    rpt_len_err = (len != LEN_EXP);
  end

  // Burst FSM: capture on an enabled rise, count g-high cycles, then wait a bounded window for the f toggle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g_q   <= 1'b1;
      len   <= '0;
      win   <= '0;
      f_ref <= 1'b0;
      early <= 1'b0;
      busy  <= 1'b0;
    end else begin
      g_q <= g_in;
      case (state)
        IDLE: begin
          if (cap) begin
            state <= MEAS;
            busy  <= 1'b1;
            len   <= LEN_ONE;
            f_ref <= f_in;
            early <= 1'b0;
          end
        end
        MEAS: begin
          if (g_in) begin
            if (len != LEN_SAT) begin
              len <= len + LEN_ONE;
            end
            if (toggled) begin
              early <= 1'b1;
            end
          end else if (toggled) begin
            state <= REPORT;
          end else begin
            state <= WAIT_F;
            win   <= '0;
          end
        end
        WAIT_F: begin
          if (toggled || (win == WIN_LAST)) begin
            state <= REPORT;
          end else begin
            win <= win + WIN_W'(1);
          end
        end
        REPORT: begin
          // a rise landing in the report cycle starts the next burst without a gap
          if (cap) begin
            state <= MEAS;
            busy  <= 1'b1;
            len   <= LEN_ONE;
            f_ref <= f_in;
            early <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Report registers: strobe for one cycle, results held until the next report
  always_ff @(posedge clk) begin
    if (rst) begin
      len_vld   <= 1'b0;
      len_out   <= '0;
      len_err   <= 1'b0;
      tog_err   <= 1'b0;
      burst_cnt <= 8'd0;
    end else begin
      len_vld <= rpt_go;
      if (rpt_go) begin
        len_out   <= len;
        len_err   <= rpt_len_err;
        tog_err   <= rpt_tog;
        burst_cnt <= burst_cnt + 8'd1;
      end
    end
  end

`ifdef HOLD_MON_STAT_EN
  // Running min/max length and saturating error count, updated on each report
  always_ff @(posedge clk) begin
    if (rst) begin
      len_min <= '1;
      len_max <= '0;
      err_cnt <= 8'd0;
    end else if (rpt_go) begin
      if (len < len_min) begin
        len_min <= len;
      end
      if (len > len_max) begin
        len_max <= len;
      end
      if ((rpt_len_err | rpt_tog) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hold_mon.sv
// Bench for hold_mon: table-driven bursts, hand-written corner sequences, randomized bursts vs a burst-level model.
module tb_hold_mon;

  localparam int LEN_W   = 4;
  localparam int EXP_LEN = 6;
  localparam int TOG_WIN = 2;
  localparam int LEN_CAP = (1 << LEN_W) - 1;

  localparam int M_NOM   = 0;  // f toggles with the first low sample
  localparam int M_LATE  = 1;  // f toggles pos low samples later
  localparam int M_NONE  = 2;  // f never toggles
  localparam int M_EARLY = 3;  // f toggles at high sample pos

  logic             clk;
  logic             rst;
  logic             g_in;
  logic             f_in;
  logic             enable;
  logic             busy;
  logic             len_vld;
  logic [LEN_W-1:0] len_out;
  logic             len_err;
  logic             tog_err;
  logic [7:0]       burst_cnt;
`ifdef HOLD_MON_STAT_EN
  logic [LEN_W-1:0] len_min;
  logic [LEN_W-1:0] len_max;
  logic [7:0]       err_cnt;
`endif

  hold_mon #(.LEN_W(LEN_W), .EXP_LEN(EXP_LEN), .TOG_WIN(TOG_WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .g_in      (g_in),
    .f_in      (f_in),
    .enable    (enable),
    .busy      (busy),
    .len_vld   (len_vld),
    .len_out   (len_out),
    .len_err   (len_err),
    .tog_err   (tog_err),
    .burst_cnt (burst_cnt)
`ifdef HOLD_MON_STAT_EN
    ,
    .len_min   (len_min),
    .len_max   (len_max),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] exp_cnt;
  int st_min, st_max, st_err;

  typedef struct {
    int n;
    int mode;
    int pos;
    int e_len;
    int e_le;
    int e_te;
    int e_lat;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    exp_cnt = 8'd0;
    st_min  = LEN_CAP;
    st_max  = 0;
    st_err  = 0;
  endtask

  task automatic model_report(input int l, input int le, input int te);
    exp_cnt = exp_cnt + 8'd1;
    if (l < st_min) st_min = l;
    if (l > st_max) st_max = l;
    if ((le != 0 || te != 0) && st_err < 255) st_err++;
  endtask

  // Burst-level reference: expected report derived from length and toggle placement
  task automatic ref_model(input int n, input int mode, input int pos,
                           output int l, output int le, output int te, output int lat);
    l   = (n > LEN_CAP) ? LEN_CAP : n;
    le  = (l != EXP_LEN) ? 1 : 0;
    te  = (mode == M_NONE || mode == M_EARLY) ? 1 : 0;
    lat = (mode == M_NONE) ? TOG_WIN + 1 : (mode == M_LATE) ? pos + 1 : 1;
  endtask

  task automatic run_burst(input string name, input int n, input int mode, input int pos,
                           input int e_len, input int e_le, input int e_te, input int e_lat,
                           input bit chain);
    int lat;
    lat = 0;
    for (int i = 0; i < n; i++) begin
      g_in = 1'b1;
      if (mode == M_EARLY && i == pos) f_in = ~f_in;
      tick();
    end
    for (int c = 0; c < 8 && lat == 0; c++) begin
      g_in = 1'b0;
      if ((mode == M_NOM && c == 0) || (mode == M_LATE && c == pos)) f_in = ~f_in;
      tick();
      if (len_vld === 1'b1) lat = c + 1;
    end
    model_report(e_len, e_le, e_te);
    check({name, " latency"}, lat, e_lat);
    check({name, " len_out"}, len_out, e_len);
    check({name, " len_err"}, len_err, e_le);
    check({name, " tog_err"}, tog_err, e_te);
    check({name, " burst_cnt"}, burst_cnt, exp_cnt);
`ifdef HOLD_MON_STAT_EN
    check({name, " len_min"}, len_min, st_min);
    check({name, " len_max"}, len_max, st_max);
    check({name, " err_cnt"}, err_cnt, st_err);
`endif
    if (!chain) begin
      g_in = 1'b0;
      tick();
      check({name, " vld_drop"}, len_vld, 0);
      check({name, " idle"}, busy, 0);
      check({name, " len_hold"}, len_out, e_len);
    end
  endtask

  initial begin
    int saw_vld, saw_busy;
    int n, mode, pos, l, le, te, lat;

    tbl[0] = '{6,  M_NOM,   0, 6,  0, 0, 1};
    tbl[1] = '{6,  M_LATE,  1, 6,  0, 0, 2};
    tbl[2] = '{6,  M_NONE,  0, 6,  0, 1, 3};
    tbl[3] = '{9,  M_EARLY, 4, 9,  1, 1, 1};
    tbl[4] = '{20, M_NOM,   0, 15, 1, 0, 1};
    tbl[5] = '{1,  M_NOM,   0, 1,  1, 0, 1};
    tbl[6] = '{15, M_LATE,  1, 15, 1, 0, 2};
    tbl[7] = '{5,  M_NONE,  0, 5,  1, 1, 3};

    // reset with g high: the burst in progress at release must be ignored
    rst = 1'b1; g_in = 1'b1; f_in = 1'b0; enable = 1'b1;
    tick(); tick();
    model_reset();
    check("rst busy", busy, 0);
    check("rst len_vld", len_vld, 0);
    check("rst len_out", len_out, 0);
    check("rst len_err", len_err, 0);
    check("rst tog_err", tog_err, 0);
    check("rst burst_cnt", burst_cnt, 0);
`ifdef HOLD_MON_STAT_EN
    check("rst len_min", len_min, LEN_CAP);
    check("rst len_max", len_max, 0);
    check("rst err_cnt", err_cnt, 0);
`endif
    rst = 1'b0;
    saw_busy = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (busy !== 1'b0) saw_busy = 1;
    end
    check("g_high_at_release ignored", saw_busy, 0);
    g_in = 1'b0;
    tick();

    // statistics sequence: 6 (clean), 4 (length error), 9 (length + toggle error)
    run_burst("stat6", 6, M_NOM,   0, 6, 0, 0, 1, 1'b0);
    run_burst("stat4", 4, M_NOM,   0, 4, 1, 0, 1, 1'b0);
    run_burst("stat9", 9, M_EARLY, 3, 9, 1, 1, 1, 1'b0);
`ifdef HOLD_MON_STAT_EN
    check("stat len_min", len_min, 4);
    check("stat len_max", len_max, 9);
    check("stat err_cnt", err_cnt, 2);
`endif

    for (int v = 0; v < 8; v++) begin
      run_burst($sformatf("tbl%0d", v), tbl[v].n, tbl[v].mode, tbl[v].pos,
                tbl[v].e_len, tbl[v].e_le, tbl[v].e_te, tbl[v].e_lat, 1'b0);
    end

    // enable low at the rise: whole burst ignored
    enable = 1'b0;
    saw_vld = 0; saw_busy = 0;
    for (int i = 0; i < 6; i++) begin
      g_in = 1'b1;
      if (i == 1) enable = 1'b1;
      tick();
      if (busy !== 1'b0) saw_busy = 1;
    end
    g_in = 1'b0; f_in = ~f_in;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (len_vld !== 1'b0) saw_vld = 1;
      if (busy !== 1'b0) saw_busy = 1;
    end
    check("enable0 no_report", saw_vld, 0);
    check("enable0 not_busy", saw_busy, 0);
    check("enable0 burst_cnt", burst_cnt, exp_cnt);

    // back-to-back: second rise lands in the REPORT cycle
    run_burst("b2b_a", 6, M_NOM, 0, 6, 0, 0, 1, 1'b1);
    run_burst("b2b_b", 4, M_NOM, 0, 4, 1, 0, 1, 1'b0);

    // randomized bursts against the burst-level model
    for (int r = 0; r < 60; r++) begin
      n    = $urandom_range(1, 20);
      mode = $urandom_range(0, 3);
      pos  = 0;
      if (mode == M_LATE) pos = $urandom_range(1, TOG_WIN - 1);
      if (mode == M_EARLY) begin
        if (n < 2) n = 2;
        pos = $urandom_range(1, n - 1);
      end
      ref_model(n, mode, pos, l, le, te, lat);
      run_burst($sformatf("rnd%0d", r), n, mode, pos, l, le, te, lat, 1'b0);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end

    // reset in the middle of MEAS aborts without a report
    for (int i = 0; i < 3; i++) begin
      g_in = 1'b1;
      tick();
    end
    check("midrst precond busy", busy, 1);
    rst = 1'b1;
    tick();
    model_reset();
    check("midrst busy", busy, 0);
    check("midrst len_vld", len_vld, 0);
    check("midrst burst_cnt", burst_cnt, 0);
    check("midrst len_out", len_out, 0);
    rst = 1'b0;
    saw_vld = 0; saw_busy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (busy !== 1'b0) saw_busy = 1;
    end
    g_in = 1'b0; f_in = ~f_in;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (len_vld !== 1'b0) saw_vld = 1;
      if (busy !== 1'b0) saw_busy = 1;
    end
    check("midrst no_report", saw_vld, 0);
    check("midrst stays_idle", saw_busy, 0);

    // 256 nominal bursts: counter wraps back to zero
    for (int b = 0; b < 256; b++) begin
      run_burst($sformatf("wrap%0d", b), 6, M_NOM, 0, 6, 0, 0, 1, 1'b0);
    end
    check("wrap burst_cnt", burst_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
